// File: rtl/bin_dn_tmr.sv
// rtl/bin_dn_tmr.sv - loadable binary down-counter/timer with terminal-count pulse and done flag.
// Optional periodic mode: define BIN_DN_TMR_AUTO_RELOAD_EN to reload from the reload register at terminal count.

module bin_dn_tmr_dff (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            q <= 1'b0;
        end else begin
            q <= d;
        end
    end

endmodule

module bin_dn_tmr #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             start,
    input  logic             en,
    output logic [WIDTH-1:0] count,
    output logic             busy,
    output logic             done,
    output logic             tc
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        COUNT = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam logic [WIDTH-1:0] ONE  = {{(WIDTH-1){1'b0}}, 1'b1};
    localparam logic [WIDTH-1:0] ZERO = '0;

    state_t           state;
    state_t           state_next;
    logic [WIDTH-1:0] count_next;
    logic [WIDTH-1:0] reload;
    logic [WIDTH-1:0] reload_next;
    logic             tc_next;

    // Count register as one flop per bit, mirroring the structural up-counter.
    for (genvar g = 0; g < WIDTH; g++) begin : g_count_bit
        bin_dn_tmr_dff u_dff (
            .clk (clk),
            .rst (rst),
            .d   (count_next[g]),
            .q   (count[g])
        );
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state  <= IDLE;
            reload <= ZERO;
            tc     <= 1'b0;
        end else begin
            state  <= state_next;
            reload <= reload_next;
            tc     <= tc_next;
        end
    end

    always_comb begin
        state_next  = state;
        count_next  = count;
        reload_next = reload;
        tc_next     = 1'b0;
        if (load) begin
            count_next  = load_val;
            reload_next = load_val;
            state_next  = IDLE;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        if (count != ZERO) begin
                            state_next = COUNT;
                        end else begin
                            state_next = DONE;
                            tc_next    = 1'b1;
                        end
                    end
                end
                COUNT: begin
                    // A zero count is unreachable here, so it simply holds.
                    if (en) begin
                        if (count > ONE) begin
                            count_next = count - ONE;
                        end else if (count == ONE) begin
                            tc_next = 1'b1;
`ifdef BIN_DN_TMR_AUTO_RELOAD_EN
                            count_next = reload;
`else
                            count_next = ZERO;
                            state_next = DONE;
`endif
                        end
                    end
                end
                DONE: begin
                    if (start) begin
                        count_next = reload;
                        if (reload != ZERO) begin
                            state_next = COUNT;
                        end else begin
                            tc_next = 1'b1;
                        end
                    end else begin
                        count_next = ZERO;
                    end
                end
                default: begin
                    state_next = IDLE;
                    count_next = ZERO;
                end
            endcase
        end
    end

    assign busy = (state == COUNT);
    assign done = (state == DONE);

endmodule

// File: tb/tb_bin_dn_tmr.sv
// tb/tb_bin_dn_tmr.sv - table-driven self-checking bench for bin_dn_tmr (WIDTH=4).

module tb_bin_dn_tmr;

    logic       clk;
    logic       rst;
    logic       load;
    logic [3:0] load_val;
    logic       start;
    logic       en;
    logic [3:0] count;
    logic       busy;
    logic       done;
    logic       tc;

    int checks;
    int errors;

    typedef struct {
        logic       ld;
        logic [3:0] lv;
        logic       st;
        logic       en;
        logic [3:0] exp_count;
        logic       exp_busy;
        logic       exp_done;
        logic       exp_tc;
    } vec_t;

    vec_t vecs[$];

    bin_dn_tmr #(.WIDTH(4)) dut (
        .clk      (clk),
        .rst      (rst),
        .load     (load),
        .load_val (load_val),
        .start    (start),
        .en       (en),
        .count    (count),
        .busy     (busy),
        .done     (done),
        .tc       (tc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual %0d required %0d", name, act, exp);
        end
    endtask

    task automatic chk_all(input string tag, input int c, input int b, input int d, input int t);
        chk({tag, " count"}, int'(count), c);
        chk({tag, " busy"},  int'(busy),  b);
        chk({tag, " done"},  int'(done),  d);
        chk({tag, " tc"},    int'(tc),    t);
    endtask

    task automatic step(input string tag, input logic ld, input logic [3:0] lv, input logic st,
                        input logic e, input int c, input int b, input int d, input int t);
        load     = ld;
        load_val = lv;
        start    = st;
        en       = e;
        @(posedge clk);
        #1;
        chk_all(tag, c, b, d, t);
        @(negedge clk);
    endtask

    task automatic add(input logic ld, input logic [3:0] lv, input logic st, input logic e,
                       input logic [3:0] c, input logic b, input logic d, input logic t);
        vec_t v;
        v.ld = ld; v.lv = lv; v.st = st; v.en = e;
        v.exp_count = c; v.exp_busy = b; v.exp_done = d; v.exp_tc = t;
        vecs.push_back(v);
    endtask

    initial begin
        checks   = 0;
        errors   = 0;
        rst      = 1'b0;
        load     = 1'b0;
        load_val = 4'd0;
        start    = 1'b0;
        en       = 1'b0;

        // Start from count 0 goes straight to DONE; reload 0 pulses tc per start.
        add(0, 0, 1, 0,  0, 0, 1, 1);
        add(0, 0, 0, 0,  0, 0, 1, 0);
        add(0, 0, 1, 0,  0, 0, 1, 1);
        add(0, 0, 1, 1,  0, 0, 1, 1);
        add(0, 0, 0, 0,  0, 0, 1, 0);
`ifdef BIN_DN_TMR_AUTO_RELOAD_EN
        add(1, 2, 0, 1,  2, 0, 0, 0);
        add(0, 0, 1, 1,  2, 1, 0, 0);
        add(0, 0, 0, 1,  1, 1, 0, 0);
        add(0, 0, 0, 1,  2, 1, 0, 1);
        add(0, 0, 0, 1,  1, 1, 0, 0);
        add(0, 0, 0, 1,  2, 1, 0, 1);
        add(0, 0, 0, 0,  2, 1, 0, 0);
        add(0, 0, 1, 1,  1, 1, 0, 0);
        add(0, 0, 0, 1,  2, 1, 0, 1);
        add(1, 5, 0, 1,  5, 0, 0, 0);
`else
        // One-shot from 3 with en held high.
        add(1, 3, 0, 1,  3, 0, 0, 0);
        add(0, 0, 1, 1,  3, 1, 0, 0);
        add(0, 0, 0, 1,  2, 1, 0, 0);
        add(0, 0, 0, 1,  1, 1, 0, 0);
        add(0, 0, 0, 1,  0, 0, 1, 1);
        add(0, 0, 0, 1,  0, 0, 1, 0);
        // Enable gating from 4: pattern 1,0,0,1,1,0,1; start ignored mid-count.
        add(1, 4, 0, 0,  4, 0, 0, 0);
        add(0, 0, 1, 0,  4, 1, 0, 0);
        add(0, 0, 0, 1,  3, 1, 0, 0);
        add(0, 0, 0, 0,  3, 1, 0, 0);
        add(0, 0, 1, 0,  3, 1, 0, 0);
        add(0, 0, 0, 1,  2, 1, 0, 0);
        add(0, 0, 0, 1,  1, 1, 0, 0);
        add(0, 0, 0, 0,  1, 1, 0, 0);
        add(0, 0, 0, 1,  0, 0, 1, 1);
        // Restart from reload 4, then load beats en at count 2.
        add(0, 0, 1, 0,  4, 1, 0, 0);
        add(0, 0, 0, 1,  3, 1, 0, 0);
        add(0, 0, 0, 1,  2, 1, 0, 0);
        add(1, 9, 0, 1,  9, 0, 0, 0);
        add(0, 0, 1, 1,  9, 1, 0, 0);
        for (int i = 8; i >= 1; i--) add(0, 0, 0, 1, 4'(i), 1, 0, 0);
        add(0, 0, 0, 1,  0, 0, 1, 1);
        add(0, 0, 1, 0,  9, 1, 0, 0);
        add(1, 0, 0, 0,  0, 0, 0, 0);
`endif

        @(posedge clk);
        @(posedge clk);
        #1;
        chk_all("reset", 0, 0, 0, 0);
        @(negedge clk);
        rst = 1'b1;

        for (int i = 0; i < vecs.size(); i++) begin
            step($sformatf("vec%0d", i), vecs[i].ld, vecs[i].lv, vecs[i].st, vecs[i].en,
                 int'(vecs[i].exp_count), int'(vecs[i].exp_busy),
                 int'(vecs[i].exp_done), int'(vecs[i].exp_tc));
        end

        // Full-width run from 15 with en held high.
        step("w15 load", 1, 15, 0, 1, 15, 0, 0, 0);
        step("w15 start", 0, 0, 1, 1, 15, 1, 0, 0);
        for (int i = 1; i <= 15; i++) begin
            if (i < 15) begin
                step($sformatf("w15 e%0d", i), 0, 0, 0, 1, 15 - i, 1, 0, 0);
            end else begin
`ifdef BIN_DN_TMR_AUTO_RELOAD_EN
                step("w15 last", 0, 0, 0, 1, 15, 1, 0, 1);
`else
                step("w15 last", 0, 0, 0, 1, 0, 0, 1, 1);
`endif
            end
        end

        // Asynchronous reset mid-count at 5, then start from count 0.
        step("rc load", 1, 7, 0, 0, 7, 0, 0, 0);
        step("rc start", 0, 0, 1, 0, 7, 1, 0, 0);
        step("rc e1", 0, 0, 0, 1, 6, 1, 0, 0);
        step("rc e2", 0, 0, 0, 1, 5, 1, 0, 0);
        rst = 1'b0;
        #1;
        chk_all("rc async", 0, 0, 0, 0);
        @(negedge clk);
        rst = 1'b1;
        step("rc post", 0, 0, 1, 0, 0, 0, 1, 1);
        step("rc idle", 0, 0, 0, 1, 0, 0, 1, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
